// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the core-side SRAM to sram-like bus adapters.
// Latency: none (declarations only); backpressure: n/a.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Read data returned to the core when the bus never answers.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/sram_wen_decode.sv
// Byte-enable decode: wen -> write flag, transfer size and aligned low address bits.
// Latency: combinational; backpressure: n/a.
module sram_wen_decode
  import cpu_bus_pkg::*;
(
  input  logic [3:0] wen,
  output logic       wr,
  output logic [1:0] size,
  output logic [1:0] addr_lo
);

  assign wr = |wen;

  // Unsupported lane patterns fall back to a full-word access at offset 0.
  always_comb begin
    size    = SZ_WORD;
    addr_lo = 2'b00;
    case (wen)
      4'b0001: begin size = SZ_BYTE; addr_lo = 2'b00; end
      4'b0010: begin size = SZ_BYTE; addr_lo = 2'b01; end
      4'b0100: begin size = SZ_BYTE; addr_lo = 2'b10; end
      4'b1000: begin size = SZ_BYTE; addr_lo = 2'b11; end
      4'b0011: begin size = SZ_HALF; addr_lo = 2'b00; end
      4'b1100: begin size = SZ_HALF; addr_lo = 2'b10; end
      default: begin size = SZ_WORD; addr_lo = 2'b00; end
    endcase
  end

endmodule

// File: rtl/sram_like_adapter.sv
// Core SRAM port to sram-like bus; stalls the core until data_ok (3+ stall cycles, one outstanding).
// Optional bus watchdog and bus_err output when SRAM_LIKE_TIMEOUT_EN is defined.
module sram_like_adapter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef SRAM_LIKE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
`ifdef SRAM_LIKE_TIMEOUT_EN
  , output logic            bus_err
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_wen;
  logic [1:0]        addr_lo;

  sram_wen_decode u_decode (
    .wen     (lat_wen),
    .wr      (bus_wr),
    .size    (bus_size),
    .addr_lo (addr_lo)
  );

  assign bus_addr  = {lat_addr[ADDR_W-1:2], addr_lo};
  assign bus_wdata = lat_wdata;
  // DONE is the single cycle in which the core may advance.
  assign cpu_stall = cpu_en & (state != DONE);

`ifdef SRAM_LIKE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             expired;
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      cpu_rdata <= 32'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_wen   <= 4'd0;
`ifdef SRAM_LIKE_TIMEOUT_EN
      cnt       <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
`ifdef SRAM_LIKE_TIMEOUT_EN
      bus_err <= 1'b0;
      if (state == REQ || state == WAIT) cnt <= cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (cpu_en) begin
            lat_addr  <= cpu_addr;
            lat_wdata <= cpu_wdata;
            lat_wen   <= cpu_wen;
            bus_req   <= 1'b1;
            state     <= REQ;
`ifdef SRAM_LIKE_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        REQ: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= WAIT;
          end
`ifdef SRAM_LIKE_TIMEOUT_EN
          else if (expired) begin
            bus_req   <= 1'b0;
            cpu_rdata <= TIMEOUT_RDATA;
            bus_err   <= 1'b1;
            state     <= DONE;
          end
`endif
        end
        WAIT: begin
          if (bus_data_ok) begin
            if (!bus_wr) cpu_rdata <= bus_rdata;
            state <= DONE;
          end
`ifdef SRAM_LIKE_TIMEOUT_EN
          else if (expired) begin
            cpu_rdata <= TIMEOUT_RDATA;
            bus_err   <= 1'b1;
            state     <= DONE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_adapter.sv
// Directed bench for sram_like_adapter: read, stores, hold, flush, reset (and watchdog when enabled).
module tb_sram_like_adapter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
`ifdef SRAM_LIKE_TIMEOUT_EN
  logic        bus_err;
  localparam int HOLD = 6;
`else
  localparam int HOLD = 10;
`endif

  int tests = 0;
  int fails = 0;
  int stalls;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  sram_like_adapter #(
    .ADDR_W(32)
`ifdef SRAM_LIKE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
`ifdef SRAM_LIKE_TIMEOUT_EN
    , .bus_err   (bus_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the edge that entered REQ; returns one step into DONE.
  task automatic complete(input logic [31:0] rdata);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = rdata;
    tick();
    bus_data_ok = 1'b0;
    bus_rdata   = 32'd0;
  endtask

  task automatic store(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] exp_size,
                       input logic [31:0] exp_addr);
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    tick();
    @(negedge clk);
    chk({tag, "_req"},   32'(bus_req), 32'd1);
    chk({tag, "_wr"},    32'(bus_wr), 32'd1);
    chk({tag, "_size"},  32'(bus_size), 32'(exp_size));
    chk({tag, "_addr"},  bus_addr, exp_addr);
    chk({tag, "_wdata"}, bus_wdata, wdata);
    #1;
    complete(32'h55AA55AA);
    @(negedge clk);
    chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
    tick();
    cpu_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    @(negedge clk);
    chk("rst_req",   32'(bus_req), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_addr",  bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_size",  32'(bus_size), 32'd2);
    tick();
    resetn = 1'b1;
    tick();

    // Read: addr_ok on first REQ cycle, data_ok two cycles later.
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'hBFC00004;
    stalls = 0;
    @(negedge clk); stalls += int'(cpu_stall);
    chk("rd_idle_req", 32'(bus_req), 32'd0);
    tick(); bus_addr_ok = 1'b1;
    @(negedge clk); stalls += int'(cpu_stall);
    chk("rd_req",  32'(bus_req), 32'd1);
    chk("rd_addr", bus_addr, 32'hBFC00004);
    chk("rd_size", 32'(bus_size), 32'd2);
    chk("rd_wr",   32'(bus_wr), 32'd0);
    tick(); bus_addr_ok = 1'b0;
    @(negedge clk); stalls += int'(cpu_stall);
    chk("rd_wait_req", 32'(bus_req), 32'd0);
    tick(); bus_data_ok = 1'b1; bus_rdata = 32'h3C1D8000;
    @(negedge clk); stalls += int'(cpu_stall);
    tick(); bus_data_ok = 1'b0; bus_rdata = 32'd0;
    @(negedge clk);
    chk("rd_done_stall", 32'(cpu_stall), 32'd0);
    chk("rd_rdata", cpu_rdata, 32'h3C1D8000);
    chk("rd_stall_cycles", 32'(stalls), 32'd4);
    tick();
    // en still high from DONE must not be reissued.
    cpu_en = 1'b0;
    @(negedge clk);
    chk("rd_no_reissue", 32'(bus_req), 32'd0);
    chk("rd_rdata_hold", cpu_rdata, 32'h3C1D8000);
    tick();

    // Stores: cpu_rdata must stay at the last read value.
    exp_rdata = 32'h3C1D8000;
    store("st_byte2", 4'b0100, 32'h80000011, 32'h00AB0000, 2'd0, 32'h80000012);
    store("st_byte3", 4'b1000, 32'h80000040, 32'hCD000000, 2'd0, 32'h80000043);
    store("st_half",  4'b1100, 32'h80000021, 32'h12340000, 2'd1, 32'h80000022);
    store("st_ill",   4'b0110, 32'h80000031, 32'h00FFFF00, 2'd2, 32'h80000030);
    store("st_word",  4'b1111, 32'h80000053, 32'hCAFEF00D, 2'd2, 32'h80000050);

    // Hold: addr_ok withheld while the core inputs wander.
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h00001000;
    tick();
    for (int i = 0; i < HOLD; i++) begin
      cpu_addr = 32'hFFFF0000 ^ 32'(i);
      cpu_wen  = 4'(i);
      @(negedge clk);
      chk("hold_addr",  bus_addr, 32'h00001000);
      chk("hold_req",   32'(bus_req), 32'd1);
      chk("hold_stall", 32'(cpu_stall), 32'd1);
      tick();
    end
    complete(32'h12345678);
    @(negedge clk);
    chk("hold_rdata", cpu_rdata, 32'h12345678);
    tick();
    cpu_en = 1'b0;
    tick();

    // Flush: en drops in WAIT, access still completes without reissue.
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h00002000;
    tick(); bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0; cpu_en = 1'b0;
    @(negedge clk);
    chk("flush_stall", 32'(cpu_stall), 32'd0);
    tick(); bus_data_ok = 1'b1; bus_rdata = 32'hAAAA5555;
    tick(); bus_data_ok = 1'b0; bus_rdata = 32'd0;
    tick();
    @(negedge clk);
    chk("flush_idle_req", 32'(bus_req), 32'd0);
    tick();

    // Reset during WAIT.
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h00003004;
    tick(); bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_mid_req",   32'(bus_req), 32'd0);
    chk("rst_mid_rdata", cpu_rdata, 32'd0);
    chk("rst_mid_addr",  bus_addr, 32'd0);
    chk("rst_mid_stall", 32'(cpu_stall), 32'd1);
    cpu_en = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h00004008;
    @(negedge clk);
    chk("post_rst_idle", 32'(bus_req), 32'd0);
    tick();
    @(negedge clk);
    chk("post_rst_req",  32'(bus_req), 32'd1);
    chk("post_rst_addr", bus_addr, 32'h00004008);
    #1;
    complete(32'h0F0F0F0F);
    @(negedge clk);
    chk("post_rst_rdata", cpu_rdata, 32'h0F0F0F0F);
    tick();
    cpu_en = 1'b0;
    tick();

`ifdef SRAM_LIKE_TIMEOUT_EN
    // Watchdog: eight cycles in REQ/WAIT without a response.
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h00005000;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_err_low", 32'(bus_err), 32'd0);
      chk("to_stall",   32'(cpu_stall), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("to_err",   32'(bus_err), 32'd1);
    chk("to_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("to_stall_low", 32'(cpu_stall), 32'd0);
    tick();
    cpu_en = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", 32'(bus_err), 32'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_like_adapter.md
Name: sram_like_adapter

Overview:
- Converts the CPU core's fixed-latency SRAM port (en/wen/addr/wdata/rdata) into the SoC's sram-like handshake bus (req/addr_ok/data_ok).
- Sits directly downstream of the CPU top. One instance serves the inst port and one serves the data port.
- Drives a stall back to the core so the pipeline holds until the bus returns data.
- Feeds the sram-like to AXI crossbar.

Parameters:
- ADDR_W, 32, address width on both sides.
- TIMEOUT_CYCLES, 255, bus watchdog limit; used only when SRAM_LIKE_TIMEOUT_EN is defined.

Ports:
- clk, input, 1, core clock.
- resetn, input, 1, asynchronous active-low reset.
- cpu_en, input, 1, access request from core.
- cpu_wen, input, 4, byte write enables; 0000 means read.
- cpu_addr, input, ADDR_W, byte address.
- cpu_wdata, input, 32, write data, byte-lane aligned.
- cpu_rdata, output, 32, read data; valid in the cycle stall falls.
- cpu_stall, output, 1, holds the core pipeline.
- bus_req, output, 1, sram-like request.
- bus_wr, output, 1, 1 means write.
- bus_size, output, 2, 0=byte, 1=half, 2=word.
- bus_addr, output, ADDR_W, request address.
- bus_wdata, output, 32, write data.
- bus_addr_ok, input, 1, request accepted.
- bus_data_ok, input, 1, read data or write acknowledgement returned.
- bus_rdata, input, 32, read data.
- bus_err, output, 1, watchdog error; present only with SRAM_LIKE_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values: state=IDLE, bus_req=0, cpu_rdata=0, latched addr/wdata/wen=0, bus_err=0.
- IDLE:
  - If cpu_en, latch cpu_addr, cpu_wdata and cpu_wen, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - bus_req=1, driven from the latched fields.
  - On bus_addr_ok, go to WAIT.
  - bus_data_ok is ignored in REQ; the bus never returns data in the accept cycle.
- WAIT:
  - bus_req=0.
  - On bus_data_ok, capture bus_rdata into cpu_rdata (reads only; cpu_rdata is unchanged on writes), then go to DONE.
- DONE:
  - Lasts one cycle; cpu_rdata is stable and the core advances.
  - Always go to IDLE next. The en/addr seen during DONE belong to the access already served and are never reissued.
- Stall: cpu_stall = cpu_en & (state != DONE), combinational.
  - Minimum latency: 3 stall cycles with addr_ok and data_ok each arriving on their first cycle.
- Request fields are stable from REQ entry until addr_ok. The core may change its inputs meanwhile without effect.
- Size and address decode (bus_wr = |wen):
  - Read (wen=0000): size=2, addr[1:0] forced to 00.
  - wen 0001 / 0010 / 0100 / 1000: size=0, addr[1:0] = 00 / 01 / 10 / 11.
  - wen 0011 / 1100: size=1, addr[1:0] = 00 / 10.
  - wen 1111: size=2, addr[1:0] = 00.
  - Any other pattern: size=2, addr[1:0]=00, full word written.
- Back-to-back accesses: at least one IDLE cycle separates consecutive requests. There is no pipelining and at most one outstanding transaction.
- Reset mid-transaction: return to IDLE immediately. The transaction is abandoned; the bus side is reset by the same resetn.
- cpu_en dropping while in REQ or WAIT (exception flush): the transaction still completes and the result is discarded. cpu_stall is low because en=0.

Optional Feature:
- Macro: SRAM_LIKE_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on leaving IDLE and counts every cycle in REQ and WAIT.
  - When the count reaches TIMEOUT_CYCLES: go to DONE, set cpu_rdata=32'hDEADBEEF, and pulse bus_err high for one cycle.
  - A late data_ok arriving after timeout is ignored.
- Undefined: no counter and no bus_err port; the block waits indefinitely.

Decomposition:
- Package cpu_bus_pkg holds:
  - state enum {IDLE, REQ, WAIT, DONE};
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the DEADBEEF constant.
- Sub-module sram_wen_decode (combinational): wen and addr[1:0] -> bus_wr, bus_size, aligned addr[1:0]. It is shared with the future AXI bridge.

Test Plan:
- Read: en=1, wen=0, addr=0xBFC00004; addr_ok at cycle 1 of REQ, data_ok 2 cycles later with rdata=0x3C1D8000 -> bus_size=2, bus_addr=0xBFC00004; stall high 4 cycles; cpu_rdata=0x3C1D8000 in DONE.
- Byte store: wen=0100, addr=0x80000011, wdata=0x00AB0000 -> bus_wr=1, bus_size=0, bus_addr=0x80000012, bus_wdata unchanged.
- Halfword store: wen=1100 -> size=1, addr[1:0]=10. Illegal wen=0110 -> size=2, addr[1:0]=00.
- Hold: addr_ok withheld 10 cycles while cpu_addr toggles -> bus_addr stays at the latched value, req high throughout, stall high.
- Reset: resetn low during WAIT -> outputs immediately return to reset values; first post-reset en issues a fresh REQ.
- With SRAM_LIKE_TIMEOUT_EN and TIMEOUT_CYCLES=8: no data_ok -> after 8 cycles bus_err pulses 1 cycle, cpu_rdata=0xDEADBEEF, stall falls for one cycle.
